// File: rtl/my_reset_sequencer.sv
// ---------------------------------------------------------------------------
// my_reset_sequencer
//
// Board-level reset/enable sequencer running on the system clock, downstream
// of the PLL. PLL lock is synchronised and glitch-filtered, then a
// programmable SDRAM power-up delay elapses before the SDRAM enable rises.
// Reset domains are released one at a time with a fixed stagger, and
// system-ready follows memory initialisation. Lock loss re-sequences from
// scratch; a software warm reset re-runs the domain release with SDRAM kept
// enabled; a memory-init timeout parks the block in FAIL.
//
// Parameters:
//   N_DOMAINS    - number of reset domains (1..8)
//   LOCK_FILTER  - consecutive synchronised lock-high cycles required (>=1)
//   SDR_DELAY    - cycles from qualified lock to SDRAM enable (>=1)
//   STAGE_DELAY  - cycles between successive domain releases (>=1)
//   INIT_TIMEOUT - max cycles waiting for memory init, 0 disables
//
// Ports:
//   i_sys_clk            in   system clock, rising edge
//   i_brd_rst_n          in   asynchronous active-low board reset
//   i_pll_locked         in   PLL lock, asynchronous
//   i_memory_initialized in   memory init done, synchronous
//   i_sw_rst             in   warm-reset request, level sampled
//   o_rst                out  per-domain active-high reset, bit 0 first
//   o_sdr_ena            out  SDRAM controller enable
//   o_system_ready       out  system ready
//   o_init_fail          out  memory init timed out
//   o_lock_loss_cnt      out  saturating lock-loss event count
//   o_state              out  current FSM state encoding
// ---------------------------------------------------------------------------
module my_reset_sequencer #(
  parameter int N_DOMAINS    = 3,
  parameter int LOCK_FILTER  = 4,
  parameter int SDR_DELAY    = 32768,
  parameter int STAGE_DELAY  = 256,
  parameter int INIT_TIMEOUT = 65536
) (
  input  logic                 i_sys_clk,
  input  logic                 i_brd_rst_n,
  input  logic                 i_pll_locked,
  input  logic                 i_memory_initialized,
  input  logic                 i_sw_rst,
  output logic [N_DOMAINS-1:0] o_rst,
  output logic                 o_sdr_ena,
  output logic                 o_system_ready,
  output logic                 o_init_fail,
  output logic [7:0]           o_lock_loss_cnt,
  output logic [2:0]           o_state
);

  // Counter widths: enough bits for the terminal value, never below one bit.
  localparam int FW = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
  localparam int DW = (SDR_DELAY    > 1) ? $clog2(SDR_DELAY)    : 1;
  localparam int SW = (STAGE_DELAY  > 1) ? $clog2(STAGE_DELAY)  : 1;
  localparam int IW = (N_DOMAINS    > 1) ? $clog2(N_DOMAINS)    : 1;
  localparam int TW = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(SDR_DELAY - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((INIT_TIMEOUT > 0) ? INIT_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX   = {TW{1'b1}};
  localparam bit            TMO_EN    = (INIT_TIMEOUT != 0);

  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [DW-1:0] DLY_ONE   = DW'(1);
  localparam logic [SW-1:0] STG_ONE   = SW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  localparam logic [FW-1:0]        FILT_ZERO = {FW{1'b0}};
  localparam logic [DW-1:0]        DLY_ZERO  = {DW{1'b0}};
  localparam logic [SW-1:0]        STG_ZERO  = {SW{1'b0}};
  localparam logic [IW-1:0]        IDX_ZERO  = {IW{1'b0}};
  localparam logic [TW-1:0]        TMO_ZERO  = {TW{1'b0}};
  localparam logic [N_DOMAINS-1:0] RST_ALL   = {N_DOMAINS{1'b1}};

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SDR_WAIT  = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_INIT = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t                 state_r,     state_s;
  logic                   sync1_r;
  logic                   lk_r;
  logic [FW-1:0]          filt_r,      filt_s;
  logic [DW-1:0]          dly_r,       dly_s;
  logic [SW-1:0]          stg_r,       stg_s;
  logic [IW-1:0]          idx_r,       idx_s;
  logic [TW-1:0]          tmo_r,       tmo_s;
  logic [N_DOMAINS-1:0]   rst_r,       rst_s;
  logic                   sdr_ena_r,   sdr_ena_s;
  logic                   sys_rdy_r,   sys_rdy_s;
  logic                   init_fail_r, init_fail_s;
  logic [7:0]             llc_r,       llc_s;

  // Next-state and next-output logic; lock loss outranks warm reset, which
  // outranks the timeout and the normal sequencing.
  always_comb begin
    state_s     = state_r;
    filt_s      = filt_r;
    dly_s       = dly_r;
    stg_s       = stg_r;
    idx_s       = idx_r;
    tmo_s       = tmo_r;
    rst_s       = rst_r;
    sdr_ena_s   = sdr_ena_r;
    sys_rdy_s   = sys_rdy_r;
    init_fail_s = init_fail_r;
    llc_s       = llc_r;

    if ((state_r != ST_WAIT_LOCK) && !lk_r) begin
      // Lock dropped after qualification: tear everything down, SDRAM too.
      state_s     = ST_WAIT_LOCK;
      filt_s      = FILT_ZERO;
      dly_s       = DLY_ZERO;
      stg_s       = STG_ZERO;
      idx_s       = IDX_ZERO;
      tmo_s       = TMO_ZERO;
      rst_s       = RST_ALL;
      sdr_ena_s   = 1'b0;
      sys_rdy_s   = 1'b0;
      init_fail_s = 1'b0;
      if (llc_r != 8'hFF) begin
        llc_s = llc_r + 8'd1;
      end else begin
        llc_s = llc_r;
      end
    end else if (i_sw_rst && ((state_r == ST_READY) || (state_r == ST_FAIL))) begin
      // Warm restart keeps SDRAM powered and only re-runs the domain release.
      state_s     = ST_RELEASE;
      stg_s       = STG_ZERO;
      idx_s       = IDX_ZERO;
      tmo_s       = TMO_ZERO;
      rst_s       = RST_ALL;
      sys_rdy_s   = 1'b0;
      init_fail_s = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (lk_r) begin
            if (filt_r == FILT_LAST) begin
              state_s = ST_SDR_WAIT;
              filt_s  = FILT_ZERO;
              dly_s   = DLY_ZERO;
            end else begin
              filt_s = filt_r + FILT_ONE;
            end
          end else begin
            filt_s = FILT_ZERO;
          end
        end

        ST_SDR_WAIT: begin
          if (dly_r == DLY_LAST) begin
            state_s   = ST_RELEASE;
            sdr_ena_s = 1'b1;
            stg_s     = STG_ZERO;
            idx_s     = IDX_ZERO;
          end else begin
            dly_s = dly_r + DLY_ONE;
          end
        end

        ST_RELEASE: begin
          if (stg_r == STG_LAST) begin
            // Stage counter is the only counter that wraps.
            stg_s        = STG_ZERO;
            rst_s[idx_r] = 1'b0;
            if (idx_r == IDX_LAST) begin
              state_s = ST_WAIT_INIT;
              tmo_s   = TMO_ZERO;
            end else begin
              idx_s = idx_r + IDX_ONE;
            end
          end else begin
            stg_s = stg_r + STG_ONE;
          end
        end

        ST_WAIT_INIT: begin
          if (i_memory_initialized) begin
            state_s   = ST_READY;
            sys_rdy_s = 1'b1;
          end else if (TMO_EN && (tmo_r == TMO_LAST)) begin
            state_s     = ST_FAIL;
            init_fail_s = 1'b1;
            rst_s       = RST_ALL;
          end else if (tmo_r != TMO_MAX) begin
            // Saturates instead of wrapping when the timeout is disabled.
            tmo_s = tmo_r + TMO_ONE;
          end else begin
            tmo_s = tmo_r;
          end
        end

        ST_READY: begin
          sys_rdy_s = i_memory_initialized;
        end

        ST_FAIL: begin
          rst_s       = RST_ALL;
          sys_rdy_s   = 1'b0;
          init_fail_s = 1'b1;
        end

        default: begin
          // Unreachable encodings recover to the fully-reset state.
          state_s     = ST_WAIT_LOCK;
          filt_s      = FILT_ZERO;
          dly_s       = DLY_ZERO;
          stg_s       = STG_ZERO;
          idx_s       = IDX_ZERO;
          tmo_s       = TMO_ZERO;
          rst_s       = RST_ALL;
          sdr_ena_s   = 1'b0;
          sys_rdy_s   = 1'b0;
          init_fail_s = 1'b0;
        end
      endcase
    end
  end

  // State, counters, outputs and the two-flop lock synchroniser.
  always_ff @(posedge i_sys_clk or negedge i_brd_rst_n) begin
    if (!i_brd_rst_n) begin
      state_r     <= ST_WAIT_LOCK;
      sync1_r     <= 1'b0;
      lk_r        <= 1'b0;
      filt_r      <= FILT_ZERO;
      dly_r       <= DLY_ZERO;
      stg_r       <= STG_ZERO;
      idx_r       <= IDX_ZERO;
      tmo_r       <= TMO_ZERO;
      rst_r       <= RST_ALL;
      sdr_ena_r   <= 1'b0;
      sys_rdy_r   <= 1'b0;
      init_fail_r <= 1'b0;
      llc_r       <= 8'd0;
    end else begin
      state_r     <= state_s;
      sync1_r     <= i_pll_locked;
      lk_r        <= sync1_r;
      filt_r      <= filt_s;
      dly_r       <= dly_s;
      stg_r       <= stg_s;
      idx_r       <= idx_s;
      tmo_r       <= tmo_s;
      rst_r       <= rst_s;
      sdr_ena_r   <= sdr_ena_s;
      sys_rdy_r   <= sys_rdy_s;
      init_fail_r <= init_fail_s;
      llc_r       <= llc_s;
    end
  end

  assign o_rst           = rst_r;
  assign o_sdr_ena       = sdr_ena_r;
  assign o_system_ready  = sys_rdy_r;
  assign o_init_fail     = init_fail_r;
  assign o_lock_loss_cnt = llc_r;
  assign o_state         = state_r;

endmodule

// File: doc/my_reset_sequencer.md
# my_reset_sequencer

- Parametrised reset/enable sequencer that runs from the system clock, downstream of the PLL.
- Qualifies PLL lock through a synchroniser and glitch filter, then enforces a programmable SDRAM power-up delay before asserting the SDRAM enable.
- Releases N reset domains one at a time with a fixed stagger, and raises system-ready once memory initialisation completes.
- Adds behaviour the single-domain version lacked: re-sequencing on lock loss, software-requested warm reset with SDRAM kept enabled, a memory-init timeout, and status outputs.

## Interface
Parameters:
- N_DOMAINS, 3: number of independently released reset domains (1..8).
- LOCK_FILTER, 4: consecutive synchronised lock-high cycles required (≥1).
- SDR_DELAY, 32768: cycles from qualified lock to o_sdr_ena rise (≥1).
- STAGE_DELAY, 256: cycles between successive domain releases (≥1).
- INIT_TIMEOUT, 65536: max cycles in WAIT_INIT before FAIL; 0 disables the timeout.

Ports:
- i_sys_clk, in, 1: single clock; all logic is on its rising edge.
- i_brd_rst_n, in, 1: reset, asynchronous and active-low.
- i_pll_locked, in, 1: PLL lock, asynchronous; 2-flop synchronised internally to lk.
- i_memory_initialized, in, 1: synchronous to i_sys_clk.
- i_sw_rst, in, 1: synchronous warm-reset request, level sampled.
- o_rst, out, N_DOMAINS: per-domain active-high reset; bit 0 is released first.
- o_sdr_ena, out, 1: SDRAM controller enable.
- o_system_ready, out, 1: registered.
- o_init_fail, out, 1: memory init timed out.
- o_lock_loss_cnt, out, 8: saturating count of lock-loss events.
- o_state, out, 3: current FSM state encoding.

## Operation
State encoding: WAIT_LOCK=0, SDR_WAIT=1, RELEASE=2, WAIT_INIT=3, READY=4, FAIL=5.

- **Async reset:** state=WAIT_LOCK; o_rst all ones; o_sdr_ena=0; o_system_ready=0; o_init_fail=0; o_lock_loss_cnt=0; synchroniser, filter and all counters=0.
- **WAIT_LOCK:** filter counter increments while lk=1 and clears on lk=0. On a cycle with lk=1 and filter==LOCK_FILTER-1: go to SDR_WAIT and clear the delay counter.
- **SDR_WAIT:** delay counter increments. At count==SDR_DELAY-1: o_sdr_ena<=1, go to RELEASE, stage index=0.
- **RELEASE:** stage counter counts 0..STAGE_DELAY-1. On wrap:
  - clear o_rst[idx] and increment idx;
  - when the last domain is cleared, go to WAIT_INIT on the same edge.
- **WAIT_INIT:**
  - i_memory_initialized=1 → READY, with o_system_ready<=1 on the same edge.
  - Otherwise the timeout counter increments. If INIT_TIMEOUT≠0 and count==INIT_TIMEOUT-1: → FAIL, o_init_fail<=1, o_rst all ones.
- **READY:** o_system_ready<=i_memory_initialized each cycle. The state holds.
- **FAIL:** o_rst all ones, o_system_ready=0, o_init_fail=1 (sticky until the next warm restart or async reset). o_sdr_ena stays 1.
- **Lock loss:** lk=0 in any state other than WAIT_LOCK → next edge:
  - state=WAIT_LOCK; o_rst all ones; o_sdr_ena=0; o_system_ready=0; o_init_fail=0;
  - all counters cleared; o_lock_loss_cnt+=1, saturating at 255.
- **Warm reset:** i_sw_rst=1 in READY or FAIL → next edge:
  - state=RELEASE, idx=0, stage counter=0; o_rst all ones; o_system_ready=0; o_init_fail=0;
  - o_sdr_ena stays 1.
  - i_sw_rst is ignored in the other states.
- **Priority:** lock loss > sw reset > timeout > normal transition.
- **Counter widths:** each counter is $clog2 of its maximum terminal value, minimum 1 bit. No counter wraps except the stage counter.

## Timing
Define t0 as the edge where the state enters SDR_WAIT. All events below are relative to t0.

- i_pll_locked rise to lk rise: 2 cycles.
- t0 is LOCK_FILTER edges after lk is first sampled high.
- o_sdr_ena rises at t0+SDR_DELAY.
- o_rst[k] falls at t0+SDR_DELAY+(k+1)·STAGE_DELAY.
- WAIT_INIT is entered on the same edge as the last release.
- o_system_ready rises 1 cycle after i_memory_initialized is sampled high in WAIT_INIT, or 1 cycle after entry if it is already high.
- Lock-loss response:
  - lk fall to all outputs forced: 1 cycle;
  - i_pll_locked fall to outputs forced: 3 cycles.
- Warm-reset response: 1 cycle.
- Release mid-sequence: a lock loss during RELEASE re-asserts any already-released domains immediately.

## Test plan
All scenarios use N_DOMAINS=3, LOCK_FILTER=4, SDR_DELAY=16, STAGE_DELAY=4, INIT_TIMEOUT=32.

1. **Cold start.** Reset released; i_pll_locked=1 from cycle 0; i_memory_initialized=1 from cycle 0.
   - Expected: SDR_WAIT at cycle 6, o_sdr_ena at 22, o_rst=110 at 26, 100 at 30, 000 at 34, o_system_ready at 35.
2. **Lock glitch.** Lock high 3 cycles, low 1 cycle, then high.
   - Expected: the filter restarts; SDR_WAIT is entered 4 cycles after lk returns high.
3. **Lock loss.** Drop lock while in READY.
   - Expected: after 3 cycles o_rst=111, o_sdr_ena=0, o_system_ready=0, o_lock_loss_cnt=1, o_state=0. Full re-sequence on relock.
4. **Init timeout.** i_memory_initialized held 0.
   - Expected: FAIL and o_init_fail=1 32 cycles after WAIT_INIT entry, o_rst=111. Then i_sw_rst pulse → RELEASE with o_sdr_ena still 1 and o_init_fail=0.
5. **Warm reset.** i_sw_rst pulse in READY.
   - Expected: o_rst=111 next cycle, o_sdr_ena stays 1, domains re-released at +4/+8/+12 cycles.
6. **Async reset mid-RELEASE.** Assert i_brd_rst_n low mid-RELEASE.
   - Expected: all outputs return to reset values immediately without a clock edge; o_lock_loss_cnt=0.
